pwm_duty_sequencer: RTL and testbench

//   Soft-ramp controller for the pwm block's 3-bit duty select (sw).

---
 rtl/pwm_duty_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - soft-ramp controller stepping the pwm duty select toward a requested target
// Optional triangle "breathe" mode is compiled in with PWM_SEQ_BREATHE_EN.
module pwm_duty_sequencer #(
  parameter int DUTY_W      = 3,
  parameter int STEP_CYCLES = 50,
  parameter int RESET_DUTY  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [DUTY_W-1:0] i_req_duty,
  output logic              o_req_ready,
  input  logic              i_pause,
  output logic [DUTY_W-1:0] o_duty_sw,
  output logic              o_busy,
`ifdef PWM_SEQ_BREATHE_EN
  output logic              o_done,
  input  logic              i_breathe
`else
  output logic              o_done
`endif
);

  localparam logic [DUTY_W-1:0] MAX_DUTY   = '1;
  localparam logic [DUTY_W-1:0] RESET_VAL  = DUTY_W'(RESET_DUTY);
  localparam logic [15:0]       TIMER_LOAD = 16'(STEP_CYCLES - 1);

`ifdef PWM_SEQ_BREATHE_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RAMP    = 2'd1,
    S_DONE    = 2'd2,
    S_BREATHE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_timer;
  logic [15:0]       w_timer_next;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] w_duty_next;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] w_target_next;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_expiry;
  logic [DUTY_W-1:0] w_duty_inc;
  logic [DUTY_W-1:0] w_duty_dec;
  logic [DUTY_W-1:0] w_ramp_duty;

`ifdef PWM_SEQ_BREATHE_EN
  logic r_dir_up;
  logic w_dir_up_next;
  logic r_exit_pend;
  logic w_exit_pend_next;
  logic w_exit_now;
`endif

  assign w_accept    = i_req_valid && r_req_ready;
  assign w_expiry    = (r_timer == 16'd0) && !i_pause;
  // Saturating neighbours so duty_sw can never wrap at either end of the code range
  assign w_duty_inc  = (r_duty == MAX_DUTY) ? r_duty : r_duty + 1'b1;
  assign w_duty_dec  = (r_duty == '0) ? r_duty : r_duty - 1'b1;
  assign w_ramp_duty = (r_target > r_duty) ? w_duty_inc : w_duty_dec;

`ifdef PWM_SEQ_BREATHE_EN
  assign w_exit_now  = r_exit_pend || !i_breathe;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_duty_next   = r_duty;
    w_target_next = r_target;
`ifdef PWM_SEQ_BREATHE_EN
    w_dir_up_next    = r_dir_up;
    w_exit_pend_next = r_exit_pend;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_req_duty == r_duty) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next  = S_RAMP;
            w_target_next = i_req_duty;
            w_timer_next  = TIMER_LOAD;
          end
`ifdef PWM_SEQ_BREATHE_EN
        end else if (i_breathe) begin
          w_state_next     = S_BREATHE;
          w_timer_next     = TIMER_LOAD;
          w_dir_up_next    = (r_duty != MAX_DUTY);
          w_exit_pend_next = 1'b0;
`endif
        end
      end
      S_RAMP: begin
        if (w_expiry) begin
          w_duty_next  = w_ramp_duty;
          w_timer_next = TIMER_LOAD;
          if (w_ramp_duty == r_target) begin
            w_state_next = S_DONE;
          end
        end else if (!i_pause) begin
          w_timer_next = r_timer - 16'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
`ifdef PWM_SEQ_BREATHE_EN
      S_BREATHE: begin
        w_exit_pend_next = w_exit_now;
        if (w_expiry) begin
          w_timer_next = TIMER_LOAD;
          // Reaching an endpoint flips direction; the endpoint itself is held for one full step
          if (r_dir_up) begin
            if (r_duty == MAX_DUTY) begin
              w_dir_up_next = 1'b0;
              w_duty_next   = w_duty_dec;
            end else begin
              w_duty_next = w_duty_inc;
            end
          end else begin
            if (r_duty == '0) begin
              w_dir_up_next = 1'b1;
              w_duty_next   = w_duty_inc;
            end else begin
              w_duty_next = w_duty_dec;
            end
          end
          if (w_exit_now) begin
            w_state_next     = S_IDLE;
            w_exit_pend_next = 1'b0;
          end
        end else if (!i_pause) begin
          w_timer_next = r_timer - 16'd1;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_timer     <= 16'd0;
      r_duty      <= RESET_VAL;
      r_target    <= RESET_VAL;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PWM_SEQ_BREATHE_EN
      r_dir_up    <= 1'b1;
      r_exit_pend <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_duty      <= w_duty_next;
      r_target    <= w_target_next;
      // Handshake flags track the state being entered so they line up with it cycle for cycle
      r_req_ready <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_DONE);
`ifdef PWM_SEQ_BREATHE_EN
      r_dir_up    <= w_dir_up_next;
      r_exit_pend <= w_exit_pend_next;
`endif
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_duty_sw   = r_duty;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - scoreboard bench for pwm_duty_sequencer with randomized targets and pause
module tb_pwm_duty_sequencer;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_duty = 3'd0;
  logic       pause = 1'b0;
  logic       ready;
  logic [2:0] duty;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .DUTY_W      (3),
    .STEP_CYCLES (STEP),
    .RESET_DUTY  (0)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_duty  (req_duty),
    .o_req_ready (ready),
    .i_pause     (pause),
    .o_duty_sw   (duty),
    .o_busy      (busy),
`ifdef PWM_SEQ_BREATHE_EN
    .o_done      (done),
    .i_breathe   (1'b0)
`else
    .o_done      (done)
`endif
  );

  typedef struct {
    int         e_cyc;
    logic [2:0] duty;
    logic       done;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_duty = 3'd0;
  logic [2:0] model_duty = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Any visible duty change or done pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && (duty !== prev_duty || done === 1'b1)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cycle %0d duty=%0d done=%0b, no event expected", cyc, duty, done);
      end else begin
        e = q.pop_front();
        if (e.e_cyc != cyc || e.duty !== duty || e.done !== done) begin
          fails++;
          $display("FAIL step_event: got cycle %0d duty %0d done %0b, expected cycle %0d duty %0d done %0b",
                   cyc, duty, done, e.e_cyc, e.duty, e.done);
        end
      end
    end
    prev_duty = duty;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", ready, 1);
  endtask

  // pmode: 0 no pause, 1 random pause, 2 six paused cycles covering the second step
  task automatic run_req(input logic [2:0] tgt, input int pmode, input bit junk);
    bit         pv[256];
    int         a;
    int         cnt;
    int         k;
    int         n;
    int         last;
    logic [2:0] d;
    ev_t        e;
    wait_ready();
    for (int j = 0; j < 256; j++) begin
      case (pmode)
        1:       pv[j] = (j < 120) && ($urandom_range(0, 3) == 0);
        2:       pv[j] = (j >= 5 && j <= 10);
        default: pv[j] = 1'b0;
      endcase
    end
    a    = cyc + 1;
    d    = model_duty;
    last = 0;
    if (tgt == d) begin
      e.e_cyc = a; e.duty = d; e.done = 1'b1;
      q.push_back(e);
    end else begin
      n   = (tgt > d) ? int'(tgt) - int'(d) : int'(d) - int'(tgt);
      cnt = 0;
      k   = 0;
      for (int j = 1; j < 256; j++) begin
        if (!pv[j]) cnt++;
        if (cnt == (k + 1) * STEP) begin
          k++;
          d = (tgt > d) ? d + 3'd1 : d - 3'd1;
          e.e_cyc = a + j; e.duty = d; e.done = (k == n);
          q.push_back(e);
          if (k == n) begin
            last = j;
            break;
          end
        end
      end
    end
    model_duty = tgt;
    req_valid  = 1'b1;
    req_duty   = tgt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int j = 1; j <= last; j++) begin
      pause = pv[j];
      if (junk && j >= 2) begin
        req_valid = 1'b1;
        req_duty  = 3'd7;
      end
      @(posedge clk); #1;
    end
    pause     = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_done;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_ready", ready, 0);
      check("reset_duty", duty, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", ready, 1);
    model_duty = 3'd0;
    prev_duty  = duty;
    mon_en     = 1'b1;

    run_req(3'd5, 0, 1'b0);
    run_req(3'd2, 0, 1'b1);
    run_req(3'd2, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      run_req(3'($urandom_range(0, 7)), 1, 1'($urandom_range(0, 1)));
    end
    run_req(3'd0, 0, 1'b0);

    wait_ready();
    mon_en    = 1'b0;
    req_valid = 1'b1;
    req_duty  = 3'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (duty !== 3'd3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midramp_reached_3", duty, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midramp_rst_duty", duty, 0);
    check("midramp_rst_busy", busy, 0);
    check("midramp_rst_done", done, 0);
    check("midramp_rst_ready", ready, 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_rst", saw_done, 0);
    check("idle_ready_after_rst", ready, 1);
    check("idle_duty_after_rst", duty, 0);
    q.delete();
    model_duty = 3'd0;
    prev_duty  = duty;
    mon_en     = 1'b1;

    run_req(3'd2, 2, 1'b0);
    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    check("events_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
